// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes/functs, ex_op encoding, comparator selects, Tuse/Tnew.
package decode_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_LUI    = 6'h0f;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUBU   = 6'h23;

  localparam logic [4:0] RA_REG    = 5'd31;

  typedef enum logic [3:0] {
    EX_NOP  = 4'd0,  EX_ADDU = 4'd1,  EX_SUBU = 4'd2,  EX_ORI  = 4'd3,
    EX_LUI  = 4'd4,  EX_LW   = 4'd5,  EX_SW   = 4'd6,  EX_BEQ  = 4'd7,
    EX_J    = 4'd8,  EX_JAL  = 4'd9,  EX_JR   = 4'd10, EX_BNE  = 4'd11,
    EX_BLEZ = 4'd12, EX_BGTZ = 4'd13, EX_BLTZ = 4'd14, EX_BGEZ = 4'd15
  } ex_op_e;

  typedef enum logic [2:0] {CMP_EQ, CMP_NE, CMP_LEZ, CMP_GTZ, CMP_LTZ, CMP_GEZ} cmp_e;
  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_UPPER, EXT_LINK} ext_e;

  // TUSE_NONE exceeds any Tnew, so an unused source never stalls
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0    = 2'd0;
  localparam logic [1:0] TNEW_1    = 2'd1;
  localparam logic [1:0] TNEW_2    = 2'd2;

  typedef struct packed {
    ex_op_e     op;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       regwrite;
    logic [4:0] waddr;
    logic [1:0] tnew;
    ext_e       ext;
    cmp_e       cmp;
    logic       is_br;
    logic       is_j;
    logic       is_jr;
  } dec_t;

  // Youngest producer (EX) shadows an older one (MEM) writing the same register.
  function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                      input logic [4:0] e_waddr, input logic [1:0] e_tnew,
                                      input logic [4:0] m_waddr, input logic [1:0] m_tnew);
    if (src == 5'd0 || tuse == TUSE_NONE) return 1'b0;
    if (src == e_waddr) return e_tnew > tuse;
    if (src == m_waddr) return m_tnew > tuse;
    return 1'b0;
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator on forwarded operands.
module branch_cmp
  import decode_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  cmp_e        cond,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CMP_EQ:  taken = (a == b);
      CMP_NE:  taken = (a != b);
      CMP_LEZ: taken = a[31] | (a == 32'd0);
      CMP_GTZ: taken = ~a[31] & (a != 32'd0);
      CMP_LTZ: taken = a[31];
      CMP_GEZ: taken = ~a[31];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID register, decode, operand forwarding, hazard stall, branch resolve, ID/EX register.
// Define DECODE_BRANCH_EXT_EN to also decode bne/blez/bgtz/bltz/bgez.
module decode_stage
  import decode_pkg::*;
#(
  parameter int          N_FWD    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_valid_i,
  input  logic [31:0]            if_pc_i,
  input  logic [31:0]            if_instr_i,
  output logic [4:0]             rf_ra1_o,
  output logic [4:0]             rf_ra2_o,
  input  logic [31:0]            rf_rd1_i,
  input  logic [31:0]            rf_rd2_i,
  input  logic [N_FWD-1:0]       fwd_valid_i,
  input  logic [N_FWD-1:0][4:0]  fwd_addr_i,
  input  logic [N_FWD-1:0][31:0] fwd_data_i,
  input  logic [4:0]             e_waddr_i,
  input  logic [4:0]             m_waddr_i,
  input  logic [1:0]             e_tnew_i,
  input  logic [1:0]             m_tnew_i,
  output logic                   stall_o,
  output logic                   redirect_o,
  output logic [31:0]            npc_o,
  output logic                   ex_valid_o,
  output logic [31:0]            ex_pc_o,
  output logic [31:0]            ex_rs_o,
  output logic [31:0]            ex_rt_o,
  output logic [31:0]            ex_imm_o,
  output logic [4:0]             ex_waddr_o,
  output logic                   ex_regwrite_o,
  output logic [1:0]             ex_tnew_o,
  output logic [3:0]             ex_op_o
);

  logic        id_valid;
  logic [31:0] id_pc, id_instr;
  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] imm26;
  dec_t        d;
  logic [31:0] rs_val, rt_val, imm_ext, pc4;
  logic        cmp_taken, bubble;

  assign opc   = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign fn    = id_instr[5:0];
  assign imm16 = id_instr[15:0];
  assign imm26 = id_instr[25:0];
  assign pc4   = id_pc + 32'd4;

  always_comb begin
    d         = '0;
    d.op      = EX_NOP;
    d.tuse_rs = TUSE_NONE;
    d.tuse_rt = TUSE_NONE;
    d.ext     = EXT_SIGN;
    d.cmp     = CMP_EQ;
    case (opc)
      OP_RTYPE: begin
        if (fn == FN_ADDU || fn == FN_SUBU) begin
          d.op = (fn == FN_ADDU) ? EX_ADDU : EX_SUBU;
          d.tuse_rs = TUSE_1; d.tuse_rt = TUSE_1;
          d.regwrite = 1'b1; d.waddr = rd; d.tnew = TNEW_1;
        end else if (fn == FN_JR) begin
          d.op = EX_JR; d.tuse_rs = TUSE_0; d.is_jr = 1'b1;
        end
      end
      OP_ORI: begin
        d.op = EX_ORI; d.tuse_rs = TUSE_1; d.ext = EXT_ZERO;
        d.regwrite = 1'b1; d.waddr = rt; d.tnew = TNEW_1;
      end
      OP_LUI: begin
        d.op = EX_LUI; d.ext = EXT_UPPER;
        d.regwrite = 1'b1; d.waddr = rt; d.tnew = TNEW_1;
      end
      OP_LW: begin
        d.op = EX_LW; d.tuse_rs = TUSE_1;
        d.regwrite = 1'b1; d.waddr = rt; d.tnew = TNEW_2;
      end
      OP_SW:  begin d.op = EX_SW; d.tuse_rs = TUSE_1; d.tuse_rt = TUSE_2; end
      OP_BEQ: begin d.op = EX_BEQ; d.tuse_rs = TUSE_0; d.tuse_rt = TUSE_0; d.is_br = 1'b1; end
      OP_J:   begin d.op = EX_J; d.is_j = 1'b1; end
      OP_JAL: begin
        d.op = EX_JAL; d.is_j = 1'b1; d.ext = EXT_LINK;
        d.regwrite = 1'b1; d.waddr = RA_REG; d.tnew = TNEW_0;
      end
`ifdef DECODE_BRANCH_EXT_EN
      OP_BNE: begin
        d.op = EX_BNE; d.tuse_rs = TUSE_0; d.tuse_rt = TUSE_0; d.is_br = 1'b1; d.cmp = CMP_NE;
      end
      OP_BLEZ: begin d.op = EX_BLEZ; d.tuse_rs = TUSE_0; d.is_br = 1'b1; d.cmp = CMP_LEZ; end
      OP_BGTZ: begin d.op = EX_BGTZ; d.tuse_rs = TUSE_0; d.is_br = 1'b1; d.cmp = CMP_GTZ; end
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          d.op = EX_BLTZ; d.tuse_rs = TUSE_0; d.is_br = 1'b1; d.cmp = CMP_LTZ;
        end else if (rt == 5'd1) begin
          d.op = EX_BGEZ; d.tuse_rs = TUSE_0; d.is_br = 1'b1; d.cmp = CMP_GEZ;
        end
      end
`endif
      default: ;
    endcase
  end

  // Descending scan so the lowest-indexed matching source wins.
  function automatic logic [31:0] fwd_sel(input logic [4:0] addr, input logic [31:0] rf);
    logic [31:0] v;
    v = rf;
    for (int i = N_FWD - 1; i >= 0; i--)
      if (fwd_valid_i[i] && fwd_addr_i[i] == addr) v = fwd_data_i[i];
    return (addr == 5'd0) ? 32'd0 : v;
  endfunction

  assign rf_ra1_o = rs;
  assign rf_ra2_o = rt;
  assign rs_val   = fwd_sel(rs, rf_rd1_i);
  assign rt_val   = fwd_sel(rt, rf_rd2_i);

  always_comb begin
    case (d.ext)
      EXT_ZERO:  imm_ext = {16'h0, imm16};
      EXT_UPPER: imm_ext = {imm16, 16'h0};
      EXT_LINK:  imm_ext = id_pc + 32'd8;
      default:   imm_ext = {{16{imm16[15]}}, imm16};
    endcase
  end

  assign stall_o = id_valid &
                   (src_hazard(rs, d.tuse_rs, e_waddr_i, e_tnew_i, m_waddr_i, m_tnew_i) |
                    src_hazard(rt, d.tuse_rt, e_waddr_i, e_tnew_i, m_waddr_i, m_tnew_i));

  branch_cmp u_cmp (.a(rs_val), .b(rt_val), .cond(d.cmp), .taken(cmp_taken));

  assign redirect_o = id_valid & ~stall_o & (d.is_j | d.is_jr | (d.is_br & cmp_taken));

  always_comb begin
    if (d.is_jr)     npc_o = rs_val;
    else if (d.is_j) npc_o = {pc4[31:28], imm26, 2'b00};
    else             npc_o = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  end

  assign bubble = stall_o | ~id_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_valid      <= 1'b0;
      id_pc         <= RESET_PC;
      id_instr      <= 32'd0;
      ex_valid_o    <= 1'b0;
      ex_pc_o       <= 32'd0;
      ex_rs_o       <= 32'd0;
      ex_rt_o       <= 32'd0;
      ex_imm_o      <= 32'd0;
      ex_waddr_o    <= 5'd0;
      ex_regwrite_o <= 1'b0;
      ex_tnew_o     <= 2'd0;
      ex_op_o       <= 4'd0;
    end else begin
      if (!stall_o) begin
        id_valid <= if_valid_i;
        id_pc    <= if_pc_i;
        id_instr <= if_instr_i;
      end
      if (bubble) begin
        ex_valid_o    <= 1'b0;
        ex_pc_o       <= 32'd0;
        ex_rs_o       <= 32'd0;
        ex_rt_o       <= 32'd0;
        ex_imm_o      <= 32'd0;
        ex_waddr_o    <= 5'd0;
        ex_regwrite_o <= 1'b0;
        ex_tnew_o     <= 2'd0;
        ex_op_o       <= 4'd0;
      end else begin
        ex_valid_o    <= 1'b1;
        ex_pc_o       <= id_pc;
        ex_rs_o       <= rs_val;
        ex_rt_o       <= rt_val;
        ex_imm_o      <= imm_ext;
        ex_waddr_o    <= d.waddr;
        ex_regwrite_o <= d.regwrite;
        ex_tnew_o     <= d.tnew;
        ex_op_o       <= d.op;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: random + directed stimulus against a behavioural model.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int NF = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                if_valid_i;
  logic [31:0]         if_pc_i, if_instr_i;
  logic [4:0]          rf_ra1_o, rf_ra2_o;
  logic [31:0]         rf_rd1_i, rf_rd2_i;
  logic [NF-1:0]       fwd_valid_i;
  logic [NF-1:0][4:0]  fwd_addr_i;
  logic [NF-1:0][31:0] fwd_data_i;
  logic [4:0]          e_waddr_i, m_waddr_i;
  logic [1:0]          e_tnew_i, m_tnew_i;
  logic                stall_o, redirect_o;
  logic [31:0]         npc_o;
  logic                ex_valid_o, ex_regwrite_o;
  logic [31:0]         ex_pc_o, ex_rs_o, ex_rt_o, ex_imm_o;
  logic [4:0]          ex_waddr_o;
  logic [1:0]          ex_tnew_o;
  logic [3:0]          ex_op_o;

  logic [31:0] regs [32];
  assign rf_rd1_i = regs[rf_ra1_o];
  assign rf_rd2_i = regs[rf_ra2_o];

  always #5 clk = ~clk;

  decode_stage #(.N_FWD(NF), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset),
    .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_instr_i(if_instr_i),
    .rf_ra1_o(rf_ra1_o), .rf_ra2_o(rf_ra2_o), .rf_rd1_i(rf_rd1_i), .rf_rd2_i(rf_rd2_i),
    .fwd_valid_i(fwd_valid_i), .fwd_addr_i(fwd_addr_i), .fwd_data_i(fwd_data_i),
    .e_waddr_i(e_waddr_i), .m_waddr_i(m_waddr_i), .e_tnew_i(e_tnew_i), .m_tnew_i(m_tnew_i),
    .stall_o(stall_o), .redirect_o(redirect_o), .npc_o(npc_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o),
    .ex_imm_o(ex_imm_o), .ex_waddr_o(ex_waddr_o), .ex_regwrite_o(ex_regwrite_o),
    .ex_tnew_o(ex_tnew_o), .ex_op_o(ex_op_o)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  waddr;
    logic        regwrite;
    logic [1:0]  tnew;
    logic [3:0]  op;
  } ex_t;

  ex_t         q[$];
  int          checks = 0, errors = 0;
  logic        m_valid;
  logic [31:0] m_pc, m_instr;
  logic        obs_stall, obs_redir;
  logic [31:0] obs_npc, fetch_pc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int i = 0; i < NF; i++)
      if (fwd_valid_i[i] && fwd_addr_i[i] == a) return fwd_data_i[i];
    return regs[a];
  endfunction

  function automatic bit haz(input logic [4:0] s, input int tuse);
    if (tuse < 0 || s == 5'd0) return 1'b0;
    if (s == e_waddr_i) return int'(e_tnew_i) > tuse;
    if (s == m_waddr_i) return int'(m_tnew_i) > tuse;
    return 1'b0;
  endfunction

  // Expected behaviour of whatever the model's IF/ID currently holds, under current inputs.
  task automatic model(output ex_t e, output bit st, output bit rd, output logic [31:0] np);
    logic [5:0]  opc, fn;
    logic [4:0]  rs, rt, rdd, wa;
    logic [15:0] i16;
    logic [31:0] a, b, imm, pc4;
    logic [1:0]  tn;
    logic [3:0]  op;
    int          urs, urt;
    bit          wr, tk;
    opc = m_instr[31:26]; rs = m_instr[25:21]; rt = m_instr[20:16];
    rdd = m_instr[15:11]; fn = m_instr[5:0];   i16 = m_instr[15:0];
    urs = -1; urt = -1; wr = 1'b0; tk = 1'b0; wa = 5'd0; tn = 2'd0; op = EX_NOP;
    a = opnd(rs); b = opnd(rt); pc4 = m_pc + 32'd4;
    imm = {{16{i16[15]}}, i16};
    np  = pc4 + imm * 32'd4;
    case (opc)
      6'h00: begin
        if (fn == 6'h21 || fn == 6'h23) begin
          op = (fn == 6'h21) ? EX_ADDU : EX_SUBU;
          urs = 1; urt = 1; wr = 1'b1; wa = rdd; tn = 2'd1;
        end else if (fn == 6'h08) begin
          op = EX_JR; urs = 0; tk = 1'b1; np = a;
        end
      end
      6'h0d: begin op = EX_ORI; urs = 1; wr = 1'b1; wa = rt; tn = 2'd1; imm = {16'h0, i16}; end
      6'h0f: begin op = EX_LUI; wr = 1'b1; wa = rt; tn = 2'd1; imm = {i16, 16'h0}; end
      6'h23: begin op = EX_LW; urs = 1; wr = 1'b1; wa = rt; tn = 2'd2; end
      6'h2b: begin op = EX_SW; urs = 1; urt = 2; end
      6'h04: begin op = EX_BEQ; urs = 0; urt = 0; tk = (a == b); end
      6'h02: begin op = EX_J; tk = 1'b1; np = {pc4[31:28], m_instr[25:0], 2'b00}; end
      6'h03: begin
        op = EX_JAL; tk = 1'b1; np = {pc4[31:28], m_instr[25:0], 2'b00};
        wr = 1'b1; wa = 5'd31; imm = m_pc + 32'd8;
      end
`ifdef DECODE_BRANCH_EXT_EN
      6'h05: begin op = EX_BNE;  urs = 0; urt = 0; tk = (a != b); end
      6'h06: begin op = EX_BLEZ; urs = 0; tk = ($signed(a) <= 0); end
      6'h07: begin op = EX_BGTZ; urs = 0; tk = ($signed(a) > 0); end
      6'h01: begin
        if (rt == 5'd0)      begin op = EX_BLTZ; urs = 0; tk = ($signed(a) < 0);  end
        else if (rt == 5'd1) begin op = EX_BGEZ; urs = 0; tk = ($signed(a) >= 0); end
      end
`endif
      default: ;
    endcase
    st = m_valid && (haz(rs, urs) || haz(rt, urt));
    rd = m_valid && tk && !st;
    if (!m_valid || st) e = '0;
    else e = '{valid: 1'b1, pc: m_pc, rs: a, rt: b, imm: imm, waddr: wa,
               regwrite: wr, tnew: tn, op: op};
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step();
    ex_t         e;
    bit          st, rd;
    logic [31:0] np;
    #2;
    model(e, st, rd, np);
    obs_stall = stall_o; obs_redir = redirect_o; obs_npc = npc_o;
    chk("stall", 32'(stall_o), 32'(st));
    chk("redirect", 32'(redirect_o), 32'(rd));
    if (rd) chk("npc", npc_o, np);
    q.push_back(e);
    if (!st) begin m_valid = if_valid_i; m_pc = if_pc_i; m_instr = if_instr_i; end
    @(posedge clk); #1;
  endtask

  always begin
    ex_t e, g;
    @(posedge clk); #2;
    if (q.size() != 0) begin
      e = q.pop_front();
      g = '{valid: ex_valid_o, pc: ex_pc_o, rs: ex_rs_o, rt: ex_rt_o, imm: ex_imm_o,
            waddr: ex_waddr_o, regwrite: ex_regwrite_o, tnew: ex_tnew_o, op: ex_op_o};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL ex_regs got=%h exp=%h", g, e);
      end
    end
  end

  task automatic do_reset(input int cyc);
    reset = 1'b0;
    q.delete();
    m_valid = 1'b0; m_pc = 32'h3000; m_instr = 32'd0;
    #1;
    chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
    chk("rst_ex_pc", ex_pc_o, 32'd0);
    chk("rst_ex_op", 32'(ex_op_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_redirect", 32'(redirect_o), 32'd0);
    chk("rst_id_pc", dut.id_pc, 32'h3000);
    repeat (cyc) @(posedge clk);
    #1;
    chk("rst_hold_ex_valid", 32'(ex_valid_o), 32'd0);
    reset = 1'b1;
  endtask

  task automatic quiet();
    if_valid_i = 1'b1; fwd_valid_i = '0; fwd_addr_i = '0; fwd_data_i = '0;
    e_waddr_i = 5'd0; e_tnew_i = 2'd0; m_waddr_i = 5'd0; m_tnew_i = 2'd0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
    if_pc_i = pc; if_instr_i = ins;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] im;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); im = 16'($urandom);
    case ($urandom_range(0, 15))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2:  return {6'h00, rs, 15'd0, 6'h08};
      3:  return {6'h0d, rs, rt, im};
      4:  return {6'h0f, 5'd0, rt, im};
      5:  return {6'h23, rs, rt, im};
      6:  return {6'h2b, rs, rt, im};
      7:  return {6'h04, rs, rt, im};
      8:  return {6'h02, 26'($urandom)};
      9:  return {6'h03, 26'($urandom)};
      10: return {6'h05, rs, rt, im};
      11: return {6'h06, rs, 5'd0, im};
      12: return {6'h07, rs, 5'd0, im};
      13: return {6'h01, rs, 5'($urandom_range(0, 1)), im};
      14: return 32'd0;
      default: return {6'h08, rs, rt, im};
    endcase
  endfunction

  task automatic rand_inputs();
    if_valid_i = ($urandom_range(0, 9) != 0);
    fetch(fetch_pc, rand_instr());
    fetch_pc = fetch_pc + 32'd4;
    e_waddr_i = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
    m_waddr_i = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'd0;
    e_tnew_i  = 2'($urandom_range(0, 2));
    m_tnew_i  = 2'($urandom_range(0, 2));
    fwd_valid_i = NF'($urandom);
    for (int i = 0; i < NF; i++) begin
      fwd_addr_i[i] = 5'($urandom_range(0, 7));
      fwd_data_i[i] = $urandom;
    end
  endtask

  initial begin
    reset = 1'b0;
    fetch_pc = 32'h3000;
    for (int i = 0; i < 32; i++) begin
      case ($urandom_range(0, 4))
        0: regs[i] = 32'd0;
        1: regs[i] = 32'd5;
        2: regs[i] = 32'hFFFF_FFFF;
        default: regs[i] = $urandom;
      endcase
    end
    regs[0] = 32'hDEAD_BEEF;
    quiet();
    fetch(32'h3000, 32'd0);
    @(posedge clk); #1;
    do_reset(2);

    // beq taken with delay slot
    quiet(); regs[1] = 32'd5; regs[2] = 32'd5;
    fetch(32'h3004, {6'h04, 5'd1, 5'd2, 16'd4}); step();
    fetch(32'h3008, {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}); step();
    chk("beq_redirect", 32'(obs_redir), 32'd1);
    chk("beq_npc", obs_npc, 32'h3018);
    fetch(32'h3018, 32'd0); step();
    chk("ds_ex_valid", 32'(ex_valid_o), 32'd1);
    chk("ds_ex_pc", ex_pc_o, 32'h3008);

    // load-use: one stall, one bubble
    quiet();
    fetch(32'h3100, {6'h00, 5'd3, 5'd5, 5'd4, 5'd0, 6'h21}); step();
    e_waddr_i = 5'd3; e_tnew_i = 2'd2;
    fetch(32'h3104, {6'h0d, 5'd0, 5'd0, 16'h0}); step();
    chk("lu_stall1", 32'(obs_stall), 32'd1);
    chk("lu_bubble", 32'(ex_valid_o), 32'd0);
    e_waddr_i = 5'd0; e_tnew_i = 2'd0; m_waddr_i = 5'd3; m_tnew_i = 2'd1; step();
    chk("lu_stall2", 32'(obs_stall), 32'd0);
    chk("lu_issue_pc", ex_pc_o, 32'h3100);

    // jr with two matching forward sources
    quiet();
    fetch(32'h3200, {6'h00, 5'd31, 15'd0, 6'h08}); step();
    fwd_valid_i = 2'b11;
    fwd_addr_i[0] = 5'd31; fwd_data_i[0] = 32'h3400;
    fwd_addr_i[1] = 5'd31; fwd_data_i[1] = 32'h9999;
    fetch(32'h3204, 32'd0); step();
    chk("jr_redirect", 32'(obs_redir), 32'd1);
    chk("jr_npc", obs_npc, 32'h3400);

    // jal link fields
    quiet();
    fetch(32'h3000, {6'h03, 26'h0000_d00}); step();
    fetch(32'h3004, 32'd0); step();
    chk("jal_redirect", 32'(obs_redir), 32'd1);
    chk("jal_waddr", 32'(ex_waddr_o), 32'd31);
    chk("jal_imm", ex_imm_o, 32'h3008);
    chk("jal_tnew", 32'(ex_tnew_o), 32'd0);

    // bgtz on a negative operand
    quiet(); regs[6] = 32'hFFFF_FFFF;
    fetch(32'h3300, {6'h07, 5'd6, 5'd0, 16'h0010}); step();
    fetch(32'h3304, 32'd0); step();
    chk("bgtz_redirect", 32'(obs_redir), 32'd0);
`ifdef DECODE_BRANCH_EXT_EN
    chk("bgtz_op", 32'(ex_op_o), 32'(EX_BGTZ));
`else
    chk("bgtz_op", 32'(ex_op_o), 32'(EX_NOP));
`endif

    // reset mid-run with a stalling addu in IF/ID
    quiet();
    fetch(32'h3500, {6'h00, 5'd3, 5'd5, 5'd4, 5'd0, 6'h21}); step();
    e_waddr_i = 5'd3; e_tnew_i = 2'd2;
    do_reset(1);

    for (int n = 0; n < 300; n++) begin rand_inputs(); step(); end
    do_reset(1);
    for (int n = 0; n < 200; n++) begin rand_inputs(); step(); end
    @(posedge clk); #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter N_FWD, default 2, meaning the number of forwarding sources (legal range 1..4).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the PC value held in the IF/ID register after reset.
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports `clk` and `reset` are listed first.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- reset  in  1  async active-low reset.
- if_valid_i  in  1  fetch slot valid.
- if_pc_i  in  32  fetch PC.
- if_instr_i  in  32  fetched instruction.
- rf_ra1_o, rf_ra2_o  out  5  register-file read addresses (rs, rt).
- rf_rd1_i, rf_rd2_i  in  32  register-file read data.
- fwd_valid_i  in  N_FWD  forward-source valid.
- fwd_addr_i  in  5*N_FWD  forward-source destination.
- fwd_data_i  in  32*N_FWD  forward-source data.
- e_waddr_i, m_waddr_i  in  5  destinations in EX and MEM.
- e_tnew_i, m_tnew_i  in  2  cycles until the EX and MEM results are ready.
- stall_o  out  1  hold PC and IF/ID.
- redirect_o  out  1  branch or jump taken.
- npc_o  out  32  redirect target.
- ex_valid_o, ex_pc_o[32], ex_rs_o[32], ex_rt_o[32], ex_imm_o[32], ex_waddr_o[5], ex_regwrite_o, ex_tnew_o[2], ex_op_o[4]  out  ID/EX register.

Function
REQ-005 SHALL hold an IF/ID register (valid, pc, instr) that loads from the if_* inputs each clock unless stall_o=1.
REQ-006 SHALL decode addu, subu, ori, lui, lw, sw, beq, j, jal, jr, and nop; any other encoding SHALL be treated as nop (regwrite=0, no redirect).
REQ-007 SHALL produce operands from the register file, overridden by the lowest-indexed forward source with fwd_valid=1 and a matching fwd_addr; address 0 SHALL always read 0.
REQ-008 SHALL use these Tuse values: rs=0 for beq and jr; rs=1 for addu, subu, ori, lw, and sw; rt=0 for beq, rt=1 for addu and subu, rt=2 for sw.
REQ-009 SHALL assert stall_o when a used source is nonzero and either (it equals e_waddr_i and e_tnew_i>Tuse) or (it equals m_waddr_i and m_tnew_i>Tuse); EX takes precedence over MEM.
REQ-010 SHALL, while stalled, load a bubble into ID/EX (ex_valid=0, ex_regwrite=0, other fields 0) and hold IF/ID.
REQ-011 SHALL compute targets as follows: branch = pc+4+(sext(imm16)<<2); j/jal = {pc+4[31:28], imm26, 2'b00}; jr = forwarded rs.
REQ-012 SHALL assert redirect_o combinationally only when IF/ID is valid, the instruction is a taken branch or jump, and stall_o=0.
REQ-013 SHALL execute the delay-slot instruction; the delay slot is never squashed.
REQ-014 SHALL give jal ex_waddr=31, ex_imm=pc+8, ex_tnew=0; lw SHALL get ex_tnew=2; ALU ops and lui SHALL get ex_tnew=1; all others SHALL get 0.
REQ-015 SHALL apply the extension rules: zero-extension for ori, upper-shift for lui, sign-extension otherwise.
REQ-016 SHALL load ID/EX one cycle after decode, giving one-cycle latency.
REQ-017 SHALL, when IF/ID is invalid, behave as nop with stall_o=0.

Reset
REQ-018 SHALL, while reset=0, force IF/ID valid=0, pc=RESET_PC, instr=0, and every ID/EX output to 0, regardless of clk.
REQ-019 SHALL not assert stall_o or redirect_o in the first cycle after reset deasserts.

Configuration
REQ-020 SHALL support macro DECODE_BRANCH_EXT_EN; when it is defined, SHALL additionally decode bne, blez, bgtz, bltz, and bgez, each with rs Tuse=0, rt Tuse=0 for bne, and the same target formula as beq.
REQ-021 SHALL, without DECODE_BRANCH_EXT_EN, decode those encodings as nop.

Structure
REQ-022 SHALL place opcode and funct constants, the ex_op encoding, and Tuse/Tnew constants in the shared package decode_pkg.
REQ-023 SHALL implement the comparator as one sub-module, branch_cmp, with inputs a and b, a condition select, and output taken.

Verification
REQ-024 SHALL cover: reset held low mid-run with an addu in IF/ID -> ex_valid=0, stall_o=0, and IF/ID pc=32'h3000 immediately.
REQ-025 SHALL cover: beq $1,$2 with both registers = 5, imm=4, pc=0x3004 -> redirect_o=1, npc_o=0x3018, delay-slot instruction reaches EX next cycle.
REQ-026 SHALL cover: lw in EX (e_tnew=2, e_waddr=3) followed by addu $4,$3,$5 -> stall_o=1 for exactly one cycle (e_tnew=1 then), one bubble issued.
REQ-027 SHALL cover: jr $31 with fwd0 valid, addr 31, data 0x3400, and fwd1 valid, addr 31, data 0x9999 -> npc_o=0x3400.
REQ-028 SHALL cover: jal at pc 0x3000 -> ex_waddr=31, ex_imm=0x3008, ex_tnew=0, redirect_o=1.
REQ-029 SHALL cover: with DECODE_BRANCH_EXT_EN defined, bgtz with rs=-1 -> redirect_o=0; without the macro, the same encoding -> nop.
